// File: rtl/uart_rx_frame_ctrl.sv
// uart_rx_frame_ctrl
//   Turns the byte stream from uart_rx into framed register-write commands.
//   Frame layout: SOF, ADDR, LEN, LEN payload bytes, CHK. CHK must equal
//   (ADDR + LEN + payload) mod 256. A verified payload is drained to a
//   valid/ready write port at consecutive addresses starting at ADDR.
//   Frames that are bad or stalled are discarded and flagged.
//
// Ports
//   i_Clock      system clock, rising edge
//   i_Rst_n      asynchronous active-low reset
//   i_Rx_DV      1-cycle strobe: i_Rx_Byte is valid
//   i_Rx_Byte    received byte
//   o_Wr_Valid   write request valid
//   o_Wr_Addr    write address
//   o_Wr_Data    write data
//   i_Wr_Ready   sink accepts the write this cycle
//   o_Busy       high whenever a frame is in progress or draining
//   o_Frame_Done 1-cycle pulse: frame fully written
//   o_Frame_Err  1-cycle pulse: frame aborted or byte overrun
//   o_Err_Code   0=checksum 1=length 2=timeout 3=overrun, held until next error
module uart_rx_frame_ctrl #(
  parameter int unsigned MAX_LEN      = 16,
  parameter int unsigned TIMEOUT_CLKS = 87000,
  parameter logic [7:0]  SOF_BYTE     = 8'hA5
) (
  input  logic       i_Clock,
  input  logic       i_Rst_n,
  input  logic       i_Rx_DV,
  input  logic [7:0] i_Rx_Byte,
  output logic       o_Wr_Valid,
  output logic [7:0] o_Wr_Addr,
  output logic [7:0] o_Wr_Data,
  input  logic       i_Wr_Ready,
  output logic       o_Busy,
  output logic       o_Frame_Done,
  output logic       o_Frame_Err,
  output logic [1:0] o_Err_Code
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_LEN, S_PAYLOAD, S_CHK, S_DRAIN
  } state_t;

  typedef enum logic [1:0] {
    ERR_CHECKSUM = 2'd0,
    ERR_LENGTH   = 2'd1,
    ERR_TIMEOUT  = 2'd2,
    ERR_OVERRUN  = 2'd3
  } err_t;

  localparam int unsigned PTR_W     = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int unsigned TO_W      = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CLKS - 1);
  localparam logic [7:0] MAX_LEN_B  = 8'(MAX_LEN);

  state_t          state, state_next;
  logic [7:0]      base_addr;
  logic [7:0]      len;
  logic [7:0]      idx;        // payload fill index, then drain index
  logic [7:0]      sum;
  logic [TO_W-1:0] to_cnt;
  logic [7:0]      pay_buf [MAX_LEN];

  logic            timed;
  logic            timeout;
  logic            transfer;
  logic            last_item;
  logic [7:0]      sum_next;
  logic            err_set;
  err_t            err_kind;
  logic            done_set;

  assign o_Busy     = (state != S_IDLE);
  assign o_Wr_Valid = (state == S_DRAIN);
  assign o_Wr_Addr  = o_Wr_Valid ? (base_addr + idx) : 8'h00;
  assign o_Wr_Data  = o_Wr_Valid ? pay_buf[idx[PTR_W-1:0]] : 8'h00;

  assign timed     = (state == S_ADDR) || (state == S_LEN) ||
                     (state == S_PAYLOAD) || (state == S_CHK);
  // An arriving byte beats the timeout in the same cycle.
  assign timeout   = timed && !i_Rx_DV && (to_cnt == TO_LAST);
  assign transfer  = o_Wr_Valid && i_Wr_Ready;
  assign last_item = ((idx + 8'd1) == len);
  assign sum_next  = sum + i_Rx_Byte;

  // NOTE: every sequential block uses non-blocking assignments so all
  // registers update from the same pre-edge values.
  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) state <= S_IDLE;
    else          state <= state_next;
  end

  always_comb begin
    // NOTE: defaults first, so no path through this block can infer a latch.
    state_next = state;
    err_set    = 1'b0;
    err_kind   = ERR_CHECKSUM;
    done_set   = 1'b0;
    case (state)
      S_IDLE: begin
        if (i_Rx_DV && (i_Rx_Byte == SOF_BYTE)) state_next = S_ADDR;
      end
      S_ADDR: begin
        if (i_Rx_DV) state_next = S_LEN;
      end
      S_LEN: begin
        if (i_Rx_DV) begin
          if (i_Rx_Byte == 8'd0) begin
            state_next = S_CHK;
          end else if (i_Rx_Byte > MAX_LEN_B) begin
            state_next = S_IDLE;
            err_set    = 1'b1;
            err_kind   = ERR_LENGTH;
          end else begin
            state_next = S_PAYLOAD;
          end
        end
      end
      S_PAYLOAD: begin
        if (i_Rx_DV && last_item) state_next = S_CHK;
      end
      S_CHK: begin
        if (i_Rx_DV) begin
          state_next = S_IDLE;
          if (i_Rx_Byte != sum) begin
            err_set  = 1'b1;
            err_kind = ERR_CHECKSUM;
          end else if (len == 8'd0) begin
            done_set = 1'b1;
          end else begin
            state_next = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        // The receiver cannot be back-pressured: a byte arriving now is lost,
        // but the verified payload still drains to completion.
        if (i_Rx_DV) begin
          err_set  = 1'b1;
          err_kind = ERR_OVERRUN;
        end
        if (transfer && last_item) begin
          state_next = S_IDLE;
          done_set   = 1'b1;
        end
      end
      default: state_next = S_IDLE;
    endcase
    if (timeout) begin
      state_next = S_IDLE;
      err_set    = 1'b1;
      err_kind   = ERR_TIMEOUT;
    end
  end

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      base_addr    <= 8'h00;
      len          <= 8'h00;
      idx          <= 8'h00;
      sum          <= 8'h00;
      to_cnt       <= '0;
      o_Frame_Done <= 1'b0;
      o_Frame_Err  <= 1'b0;
      o_Err_Code   <= 2'd0;
    end else begin
      o_Frame_Done <= done_set;
      o_Frame_Err  <= err_set;
      if (err_set) o_Err_Code <= err_kind;

      if (!timed || i_Rx_DV || (state_next != state)) to_cnt <= '0;
      else                                            to_cnt <= to_cnt + 1'b1;

      case (state)
        S_ADDR: if (i_Rx_DV) begin
          base_addr <= i_Rx_Byte;
          sum       <= i_Rx_Byte;
        end
        S_LEN: if (i_Rx_DV) begin
          len <= i_Rx_Byte;
          sum <= sum_next;
          idx <= 8'h00;
        end
        S_PAYLOAD: if (i_Rx_DV) begin
          sum <= sum_next;
          idx <= idx + 8'd1;
        end
        S_CHK:   if (i_Rx_DV) idx <= 8'h00;
        S_DRAIN: if (transfer) idx <= idx + 8'd1;
        default: ;
      endcase
    end
  end

  // NOTE: the payload buffer has no reset; it is always written before it is
  // read, and leaving it unreset lets it map onto plain RAM/flops.
  always_ff @(posedge i_Clock) begin
    if ((state == S_PAYLOAD) && i_Rx_DV) pay_buf[idx[PTR_W-1:0]] <= i_Rx_Byte;
  end

endmodule
